neuron_train_sequencer: RTL and testbench

- Controller that sequences training of the two-input Neuron datapath.
- Holds a local sample store of (x1, x2, t) triples, loaded word by word.
- On start, streams samples to the Neuron through its requestFlag/dataReady handshake, wrapping over the set epoch after epoch.
- Stops on the Neuron's done or on an epoch limit.
- Sits between the sample source (host/loader) and the Neuron, replacing the bench-side feed loop.

---
 rtl/neuron_train_sequencer_if.sv | 34 +++
 rtl/neuron_train_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_neuron_train_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_train_sequencer_if.sv
// neuron_train_sequencer_if: Neuron-side sample handshake.
// The sequencer is the master; the Neuron is the slave.
interface neuron_train_sequencer_if #(
  parameter int X_W = 7,
  parameter int T_W = 2
);
  logic                  requestFlag;
  logic                  done;
  logic [31:0]           nInput;
  logic signed [X_W-1:0] x1Input;
  logic signed [X_W-1:0] x2Input;
  logic signed [T_W-1:0] tInput;
  logic                  dataReady;

  modport master (
    input  requestFlag,
    input  done,
    output nInput,
    output x1Input,
    output x2Input,
    output tInput,
    output dataReady
  );

  modport slave (
    output requestFlag,
    output done,
    input  nInput,
    input  x1Input,
    input  x2Input,
    input  tInput,
    input  dataReady
  );
endinterface

// File: rtl/neuron_train_sequencer.sv
// neuron_train_sequencer: loads (x1,x2,t) samples into a local
// store and streams them to the Neuron epoch after epoch.
module neuron_train_sequencer #(
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = 9,
  parameter int X_W        = 7,
  parameter int T_W        = 2,
  parameter int EPOCH_W    = 16,
  parameter int MAX_EPOCHS = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_clr,
  input  logic                  load_we,
  input  logic signed [X_W-1:0] load_x1,
  input  logic signed [X_W-1:0] load_x2,
  input  logic signed [T_W-1:0] load_t,
  input  logic                  start,
  input  logic                  abort,
  neuron_train_sequencer_if.master nif,
  output logic                  busy,
  output logic                  finished,
  output logic                  timeout,
  output logic                  overflow,
  output logic                  start_err,
  output logic [EPOCH_W-1:0]    epoch,
  output logic [ADDR_W:0]       sample_idx
);

  localparam int W = 2*X_W + T_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;
  localparam logic [ADDR_W:0] CNT_FULL = DEPTH[ADDR_W:0];
  localparam logic [EPOCH_W-1:0] EP_ONE = 1;
  localparam logic [EPOCH_W-1:0] EP_MAX = EPOCH_W'(MAX_EPOCHS);

  typedef enum logic [2:0] {
    IDLE, WAIT_REQ, FETCH, PRESENT, GAP
  } state_t;

  state_t state, state_n;

  logic [W-1:0]     mem [DEPTH];
  logic [W-1:0]     rdata;
  logic [ADDR_W:0]  count;
  logic             in_idle;
  logic             full;
  logic             wr_en;
  logic             last;
  logic             ep_end;
  logic [EPOCH_W-1:0] epoch_inc;

  logic rd_en;
  logic do_start;
  logic set_serr;
  logic set_fin;
  logic set_to;
  logic present;
  logic fetch;

  assign in_idle   = (state == IDLE);
  assign full      = (count == CNT_FULL);
  assign wr_en     = in_idle && !load_clr && load_we && !full;
  assign last      = (sample_idx == count - CNT_ONE);
  assign epoch_inc = epoch + EP_ONE;
  assign ep_end    = last && (epoch_inc == EP_MAX);

  assign busy          = !in_idle;
  assign nif.nInput    = 32'(count);
  assign nif.dataReady = present;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_n  = state;
    rd_en    = 1'b0;
    do_start = 1'b0;
    set_serr = 1'b0;
    set_fin  = 1'b0;
    set_to   = 1'b0;
    present  = 1'b0;
    fetch    = 1'b0;
    if (abort && !in_idle) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              set_serr = 1'b1;
            end else begin
              do_start = 1'b1;
              state_n  = WAIT_REQ;
            end
          end
        end
        WAIT_REQ: begin
          if (nif.done) begin
            set_fin = 1'b1;
            state_n = IDLE;
          end else if (nif.requestFlag) begin
            rd_en   = 1'b1;
            state_n = FETCH;
          end
        end
        FETCH: begin
          fetch   = 1'b1;
          state_n = PRESENT;
        end
        PRESENT: begin
          present = 1'b1;
          if (ep_end) begin
            set_to  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = GAP;
          end
        end
        GAP: begin
          if (nif.done) begin
            set_fin = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT_REQ;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Sample RAM: append writes while idle, sync read on request.
  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      mem[count[ADDR_W-1:0]] <= {load_x1, load_x2, load_t};
    if (!rst && rd_en)
      rdata <= mem[sample_idx[ADDR_W-1:0]];
  end

  // Store count and overflow flag, only touched while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (in_idle) begin
      if (load_clr) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (load_we) begin
        if (full) overflow <= 1'b1;
        else      count    <= count + CNT_ONE;
      end
    end
  end

  // Sample output registers, loaded from RAM in FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      nif.x1Input <= '0;
      nif.x2Input <= '0;
      nif.tInput  <= '0;
    end else if (fetch) begin
      {nif.x1Input, nif.x2Input, nif.tInput} <= rdata;
    end
  end

  // Progress counters and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      epoch      <= '0;
      sample_idx <= '0;
      finished   <= 1'b0;
      timeout    <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      if (do_start) begin
        epoch      <= '0;
        sample_idx <= '0;
        finished   <= 1'b0;
        timeout    <= 1'b0;
        start_err  <= 1'b0;
      end
      if (set_serr) start_err <= 1'b1;
      if (set_fin)  finished  <= 1'b1;
      if (set_to)   timeout   <= 1'b1;
      if (present) begin
        if (last) begin
          sample_idx <= '0;
          epoch      <= epoch_inc;
        end else begin
          sample_idx <= sample_idx + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_train_sequencer.sv
// tb_neuron_train_sequencer: randomized scoreboard bench,
// expected presentations queued at start, popped on dataReady.
module tb_neuron_train_sequencer;

  localparam int DEPTH   = 512;
  localparam int ADDR_W  = 9;
  localparam int X_W     = 7;
  localparam int T_W     = 2;
  localparam int EPOCH_W = 16;
  localparam int MAXE    = 2;

  typedef struct packed {
    logic [X_W-1:0] x1;
    logic [X_W-1:0] x2;
    logic [T_W-1:0] t;
  } samp_t;

  typedef struct packed {
    samp_t s;
    int    ep;
    int    idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_clr = 1'b0;
  logic load_we = 1'b0;
  logic signed [X_W-1:0] load_x1 = '0;
  logic signed [X_W-1:0] load_x2 = '0;
  logic signed [T_W-1:0] load_t = '0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, finished, timeout, overflow, start_err;
  logic [EPOCH_W-1:0] epoch;
  logic [ADDR_W:0] sample_idx;

  neuron_train_sequencer_if #(.X_W(X_W), .T_W(T_W)) nif();

  neuron_train_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .X_W(X_W), .T_W(T_W),
    .EPOCH_W(EPOCH_W), .MAX_EPOCHS(MAXE)
  ) dut (
    .clk(clk), .rst(rst),
    .load_clr(load_clr), .load_we(load_we),
    .load_x1(load_x1), .load_x2(load_x2), .load_t(load_t),
    .start(start), .abort(abort),
    .nif(nif),
    .busy(busy), .finished(finished), .timeout(timeout),
    .overflow(overflow), .start_err(start_err),
    .epoch(epoch), .sample_idx(sample_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int npulse = 0;
  int pulse_cyc[$];
  samp_t store[$];
  exp_t expq[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: every dataReady pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (nif.dataReady === 1'b1) begin
      npulse++;
      pulse_cyc.push_back(cyc_cnt);
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=%0d required=none",
                 npulse);
      end else begin
        e = expq.pop_front();
        chk("sample", 32'({nif.x1Input, nif.x2Input, nif.tInput}),
            32'(e.s));
        chk("pulse_epoch", 32'(epoch), 32'(e.ep));
        chk("pulse_idx", 32'(sample_idx), 32'(e.idx));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(samp_t s);
    load_x1 = s.x1;
    load_x2 = s.x2;
    load_t  = s.t;
    load_we = 1'b1;
    cyc(1);
    load_we = 1'b0;
    if (store.size() < DEPTH) store.push_back(s);
  endtask

  task automatic load_rand(int n);
    samp_t s;
    for (int i = 0; i < n; i++) begin
      s.x1 = X_W'($urandom);
      s.x2 = X_W'($urandom);
      s.t  = T_W'($urandom);
      load(s);
    end
  endtask

  task automatic clr();
    load_clr = 1'b1;
    cyc(1);
    load_clr = 1'b0;
    store.delete();
  endtask

  // Reference: pulse k presents sample k mod n in epoch k div n.
  task automatic expect_pulses(int np);
    exp_t e;
    int n;
    n = store.size();
    for (int k = 0; k < np; k++) begin
      e.s   = store[k % n];
      e.ep  = k / n;
      e.idx = k % n;
      expq.push_back(e);
    end
  endtask

  task automatic go();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(string nm, int lim);
    int k;
    k = 0;
    while (busy && k < lim) begin
      cyc(1);
      k++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s_wait actual=busy required=idle", nm);
    end
  endtask

  task automatic wait_pulses(string nm, int base, int np);
    int k;
    k = 0;
    while (npulse - base < np && k < 200) begin
      cyc(1);
      k++;
    end
    if (npulse - base < np) begin
      checks++;
      failures++;
      $display("FAIL %s_wait actual=%0d required=%0d",
               nm, npulse - base, np);
    end
  endtask

  function automatic samp_t mk(int a, int b, int c);
    samp_t s;
    s.x1 = X_W'(a);
    s.x2 = X_W'(b);
    s.t  = T_W'(c);
    return s;
  endfunction

  initial begin
    int base;
    int c0;
    int n;
    nif.requestFlag = 1'b0;
    nif.done = 1'b0;

    rst = 1'b1;
    cyc(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({finished, timeout, overflow, start_err}), 0);
    chk("rst_epoch", 32'(epoch), 0);
    chk("rst_idx", 32'(sample_idx), 0);
    chk("rst_n", nif.nInput, 0);
    chk("rst_dr", 32'(nif.dataReady), 0);
    rst = 1'b0;
    cyc(1);

    // Four fixed samples, requestFlag held high.
    load(mk(3, -2, 1));
    load(mk(-5, 4, -1));
    load(mk(10, 1, 1));
    load(mk(-1, -7, -1));
    chk("n4", nif.nInput, 4);
    expect_pulses(4 * MAXE);
    nif.requestFlag = 1'b1;
    pulse_cyc.delete();
    go();
    c0 = cyc_cnt;
    chk("busy_run", 32'(busy), 1);
    wait_idle("t1", 100);
    chk("t1_npulse", 32'(pulse_cyc.size()), 4 * MAXE);
    if (pulse_cyc.size() > 0)
      chk("t1_lat", 32'(pulse_cyc[0] - c0), 2);
    for (int i = 1; i < pulse_cyc.size(); i++)
      chk("t1_period", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 4);
    chk("t1_to", 32'(timeout), 1);
    chk("t1_fin", 32'(finished), 0);
    chk("t1_epoch", 32'(epoch), MAXE);
    chk("t1_idx", 32'(sample_idx), 0);
    chk("t1_q", 32'(expq.size()), 0);

    // done raised in the GAP after the fifth pulse.
    expect_pulses(5);
    base = npulse;
    go();
    chk("t2_clr_to", 32'(timeout), 0);
    wait_pulses("t2", base, 5);
    nif.done = 1'b1;
    cyc(1);
    nif.done = 1'b0;
    chk("t2_fin", 32'(finished), 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_epoch", 32'(epoch), 1);
    chk("t2_idx", 32'(sample_idx), 1);
    cyc(6);
    chk("t2_npulse", 32'(npulse - base), 5);
    chk("t2_q", 32'(expq.size()), 0);

    // done and requestFlag together in WAIT_REQ.
    base = npulse;
    nif.done = 1'b1;
    go();
    cyc(1);
    nif.done = 1'b0;
    chk("t3_fin", 32'(finished), 1);
    chk("t3_busy", 32'(busy), 0);
    cyc(5);
    chk("t3_npulse", 32'(npulse - base), 0);

    // abort during FETCH of the third sample.
    expect_pulses(2);
    base = npulse;
    go();
    chk("t4_clr_fin", 32'(finished), 0);
    wait_pulses("t4", base, 2);
    cyc(2);
    chk("t4_busy_pre", 32'(busy), 1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_idx", 32'(sample_idx), 2);
    chk("t4_epoch", 32'(epoch), 0);
    chk("t4_flags", 32'({finished, timeout}), 0);
    cyc(6);
    chk("t4_npulse", 32'(npulse - base), 2);

    // Three samples run to the epoch limit; loads ignored while busy.
    clr();
    load(mk(7, -8, 1));
    load(mk(-64, 63, -2));
    load(mk(0, 1, 0));
    expect_pulses(3 * MAXE);
    base = npulse;
    go();
    cyc(3);
    load_x1 = 7'sd5;
    load_we = 1'b1;
    cyc(1);
    load_we = 1'b0;
    load_clr = 1'b1;
    cyc(1);
    load_clr = 1'b0;
    chk("t5_n_busy", nif.nInput, 3);
    wait_idle("t5", 100);
    chk("t5_npulse", 32'(npulse - base), 3 * MAXE);
    chk("t5_to", 32'(timeout), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_epoch", 32'(epoch), MAXE);
    chk("t5_fin", 32'(finished), 0);
    chk("t5_q", 32'(expq.size()), 0);

    // Random sets and random requestFlag.
    for (int r = 0; r < 6; r++) begin
      clr();
      n = (r == 0) ? 1 : $urandom_range(1, 7);
      load_rand(n);
      expect_pulses(n * MAXE);
      base = npulse;
      nif.requestFlag = 1'($urandom);
      go();
      for (int k = 0; k < 400 && busy; k++) begin
        nif.requestFlag = 1'($urandom);
        cyc(1);
      end
      wait_idle("rnd", 100);
      chk("rnd_npulse", 32'(npulse - base), n * MAXE);
      chk("rnd_to", 32'(timeout), 1);
      chk("rnd_epoch", 32'(epoch), MAXE);
      chk("rnd_q", 32'(expq.size()), 0);
    end
    nif.requestFlag = 1'b0;

    // Fill, overflow, clear, empty start.
    clr();
    load_rand(DEPTH);
    chk("full_n", nif.nInput, DEPTH);
    chk("full_ovf", 32'(overflow), 0);
    load_rand(1);
    chk("ovf", 32'(overflow), 1);
    chk("ovf_n", nif.nInput, DEPTH);
    clr();
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_n", nif.nInput, 0);
    go();
    chk("serr", 32'(start_err), 1);
    chk("serr_busy", 32'(busy), 0);
    cyc(2);
    chk("serr_busy2", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
